// File: rtl/div_restoring.sv
// Sequential restoring shift-subtract divider with init/done four-phase handshake.
// Define SIGNED_DIV_EN for two's-complement operands (adds a sign-fix state).
module div_restoring #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             divByZero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_CHECK = 3'd4,
    S_END   = 3'd5
`ifdef SIGNED_DIV_EN
    , S_FIX = 3'd6
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             divByZero_q, divByZero_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SIGNED_DIV_EN
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      divByZero_q <= 1'b0;
      cnt_q       <= '0;
`ifdef SIGNED_DIV_EN
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      divByZero_q <= divByZero_d;
      cnt_q       <= cnt_d;
`ifdef SIGNED_DIV_EN
      sq_q        <= sq_d;
      sr_q        <= sr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    divByZero_d = divByZero_q;
    cnt_d       = cnt_q;
`ifdef SIGNED_DIV_EN
    sq_d        = sq_q;
    sr_d        = sr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (init_i) begin
`ifdef SIGNED_DIV_EN
          q_d       = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
          divisor_d = divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
          sq_d      = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
          sr_d      = dividend_i[WIDTH-1];
`else
          q_d       = dividend_i;
          divisor_d = divisor_i;
`endif
          divByZero_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (divisor_q == '0) begin
          quot_d      = '1;
`ifdef SIGNED_DIV_EN
          // Q holds the magnitude, so restore the original dividend here
          rem_d       = sr_q ? -q_q : q_q;
`else
          rem_d       = q_q;
`endif
          divByZero_d = 1'b1;
          state_d     = S_END;
        end else begin
          a_d     = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
        state_d    = S_SUB;
      end
      S_SUB: begin
        a_d     = a_q - {1'b0, divisor_q};
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (a_q[WIDTH]) begin
          a_d = a_q + {1'b0, divisor_q};
          q_d = {q_q[WIDTH-1:1], 1'b0};
        end else begin
          q_d = {q_q[WIDTH-1:1], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d = q_d;
          rem_d  = a_d[WIDTH-1:0];
`ifdef SIGNED_DIV_EN
          state_d = S_FIX;
`else
          state_d = S_END;
`endif
        end else begin
          state_d = S_SHIFT;
        end
      end
`ifdef SIGNED_DIV_EN
      S_FIX: begin
        if (sq_q) quot_d = -quot_q;
        if (sr_q) rem_d = -rem_q;
        state_d = S_END;
      end
`endif
      S_END: begin
        if (!init_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign divByZero_o = divByZero_q;
  assign done_o      = (state_q == S_END);
`ifdef SIGNED_DIV_EN
  assign busy_o = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_SUB) ||
                  (state_q == S_CHECK) || (state_q == S_FIX);
`else
  assign busy_o = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_SUB) ||
                  (state_q == S_CHECK);
`endif

endmodule

// File: tb/tb_div_restoring.sv
// Directed bench for div_restoring (WIDTH=16): results, latency, handshake, reset, divide-by-zero.
module tb_div_restoring;

`ifdef SIGNED_DIV_EN
  localparam int LAT = 51;
`else
  localparam int LAT = 50;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_i = 1'b0;
  logic [15:0] dividend_i = '0;
  logic [15:0] divisor_i = '0;
  logic [15:0] quotient_o, remainder_o;
  logic        done_o, busy_o, divByZero_o;

  int total = 0;
  int bad = 0;

  div_restoring #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .init_i(init_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .quotient_o(quotient_o), .remainder_o(remainder_o),
    .done_o(done_o), .busy_o(busy_o), .divByZero_o(divByZero_o)
  );

  always #5 clk = ~clk;

  // Raises init with operands, scrambles operands after the capture edge and waits for done.
  task automatic runDiv(input logic [15:0] a, input logic [15:0] b,
                        output int edgeN, output int busyLow);
    @(negedge clk);
    dividend_i = a;
    divisor_i  = b;
    init_i     = 1'b1;
    edgeN   = 0;
    busyLow = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        dividend_i = 16'hDEAD;
        divisor_i  = 16'hBEEF;
      end
      if (done_o) begin
        edgeN = k;
        break;
      end
      if (!busy_o) busyLow++;
    end
  endtask

  task automatic dropInit();
    @(negedge clk);
    init_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (quotient_o !== 16'h0) begin bad++; $display("[TB] FAIL reset_quotient got=%h exp=0000", quotient_o); end
    total++; if (remainder_o !== 16'h0) begin bad++; $display("[TB] FAIL reset_remainder got=%h exp=0000", remainder_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (divByZero_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_dbz got=%b exp=0", divByZero_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e, bl;
    runDiv(16'd100, 16'd7, e, bl);
    total++; if (e != LAT) begin bad++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", e, LAT); end
    total++; if (bl != 0) begin bad++; $display("[TB] FAIL basic_busy low_cycles=%0d exp=0", bl); end
    total++; if (quotient_o !== 16'd14) begin bad++; $display("[TB] FAIL basic_quotient got=%0d exp=14", quotient_o); end
    total++; if (remainder_o !== 16'd2) begin bad++; $display("[TB] FAIL basic_remainder got=%0d exp=2", remainder_o); end
    total++; if (divByZero_o !== 1'b0) begin bad++; $display("[TB] FAIL basic_dbz got=%b exp=0", divByZero_o); end
    dropInit();
    total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_drop got=%b exp=0", done_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL basic_idle_busy got=%b exp=0", busy_o); end
    total++; if (quotient_o !== 16'd14) begin bad++; $display("[TB] FAIL basic_hold got=%0d exp=14", quotient_o); end
  endtask

  task automatic test_corners();
    int e, bl;
    runDiv(16'hFFFF, 16'h0001, e, bl);
    total++; if (quotient_o !== 16'hFFFF) begin bad++; $display("[TB] FAIL max_quotient got=%h exp=ffff", quotient_o); end
    total++; if (remainder_o !== 16'h0) begin bad++; $display("[TB] FAIL max_remainder got=%h exp=0000", remainder_o); end
    dropInit();
    runDiv(16'd3, 16'd10, e, bl);
    total++; if (quotient_o !== 16'd0) begin bad++; $display("[TB] FAIL small_quotient got=%0d exp=0", quotient_o); end
    total++; if (remainder_o !== 16'd3) begin bad++; $display("[TB] FAIL small_remainder got=%0d exp=3", remainder_o); end
    total++; if (e != LAT) begin bad++; $display("[TB] FAIL small_latency got=%0d exp=%0d", e, LAT); end
    dropInit();
  endtask

  task automatic test_div_zero();
    int e, bl;
    runDiv(16'd5, 16'd0, e, bl);
    total++; if (e != 2) begin bad++; $display("[TB] FAIL dz_latency got=%0d exp=2", e); end
    total++; if (divByZero_o !== 1'b1) begin bad++; $display("[TB] FAIL dz_flag got=%b exp=1", divByZero_o); end
    total++; if (quotient_o !== 16'hFFFF) begin bad++; $display("[TB] FAIL dz_quotient got=%h exp=ffff", quotient_o); end
    total++; if (remainder_o !== 16'd5) begin bad++; $display("[TB] FAIL dz_remainder got=%0d exp=5", remainder_o); end
    dropInit();
    total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL dz_done_drop got=%b exp=0", done_o); end
    total++; if (divByZero_o !== 1'b1) begin bad++; $display("[TB] FAIL dz_flag_hold got=%b exp=1", divByZero_o); end
  endtask

  task automatic test_handshake();
    int e, bl;
    int unstable;
    runDiv(16'd1000, 16'd3, e, bl);
    total++; if (quotient_o !== 16'd333 || remainder_o !== 16'd1) begin bad++; $display("[TB] FAIL hs_first got=%0d/%0d exp=333/1", quotient_o, remainder_o); end
    total++; if (divByZero_o !== 1'b0) begin bad++; $display("[TB] FAIL hs_dbz_cleared got=%b exp=0", divByZero_o); end
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (!done_o || quotient_o !== 16'd333 || remainder_o !== 16'd1 || busy_o) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("[TB] FAIL hs_hold unstable_cycles=%0d exp=0", unstable); end
    dropInit();
    runDiv(16'd200, 16'd9, e, bl);
    total++; if (quotient_o !== 16'd22) begin bad++; $display("[TB] FAIL hs_quotient got=%0d exp=22", quotient_o); end
    total++; if (remainder_o !== 16'd2) begin bad++; $display("[TB] FAIL hs_remainder got=%0d exp=2", remainder_o); end
    total++; if (e != LAT) begin bad++; $display("[TB] FAIL hs_latency got=%0d exp=%0d", e, LAT); end
    dropInit();
  endtask

  task automatic test_reset_mid();
    int e, bl;
    @(negedge clk);
    dividend_i = 16'd1234;
    divisor_i  = 16'd7;
    init_i     = 1'b1;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    init_i = 1'b0;
    @(posedge clk);
    #1;
    total++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_state busy=%b done=%b exp=0/0", busy_o, done_o); end
    total++; if (quotient_o !== 16'h0 || remainder_o !== 16'h0 || divByZero_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_outputs q=%h r=%h dz=%b exp=0", quotient_o, remainder_o, divByZero_o); end
    @(negedge clk);
    rst = 1'b0;
    runDiv(16'd50, 16'd5, e, bl);
    total++; if (quotient_o !== 16'd10 || remainder_o !== 16'd0) begin bad++; $display("[TB] FAIL mid_rst_next got=%0d/%0d exp=10/0", quotient_o, remainder_o); end
    total++; if (e != LAT) begin bad++; $display("[TB] FAIL mid_rst_latency got=%0d exp=%0d", e, LAT); end
    dropInit();
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    int e, bl;
    runDiv(-16'sd7, 16'd2, e, bl);
    total++; if (e != 51) begin bad++; $display("[TB] FAIL s_latency got=%0d exp=51", e); end
    total++; if (quotient_o !== 16'hFFFD || remainder_o !== 16'hFFFF) begin bad++; $display("[TB] FAIL s_neg_dividend got=%h/%h exp=fffd/ffff", quotient_o, remainder_o); end
    dropInit();
    runDiv(16'd7, -16'sd2, e, bl);
    total++; if (quotient_o !== 16'hFFFD || remainder_o !== 16'h0001) begin bad++; $display("[TB] FAIL s_neg_divisor got=%h/%h exp=fffd/0001", quotient_o, remainder_o); end
    dropInit();
    runDiv(16'h8000, 16'hFFFF, e, bl);
    total++; if (quotient_o !== 16'h8000 || remainder_o !== 16'h0000) begin bad++; $display("[TB] FAIL s_overflow got=%h/%h exp=8000/0000", quotient_o, remainder_o); end
    dropInit();
    runDiv(-16'sd5, 16'd0, e, bl);
    total++; if (e != 2 || quotient_o !== 16'hFFFF || remainder_o !== 16'hFFFB) begin bad++; $display("[TB] FAIL s_div_zero edge=%0d got=%h/%h exp=2 ffff/fffb", e, quotient_o, remainder_o); end
    dropInit();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_handshake();
    test_reset_mid();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
